digit_serial_addsub: RTL and testbench
======================================

DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and result width in bits (legal values 4..64).
REQ-002 The block SHALL have parameter DIGIT, default 4, meaning bits processed per cycle; WIDTH % DIGIT == 0 is required, with NDIG = WIDTH/DIGIT.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-008 The block SHALL have ports x and y, input, WIDTH bits each: two's-complement operands.
REQ-009 The block SHALL have port sel, input, 1 bit: 0 = x+y, 1 = x-y.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-013 The block SHALL have ports c_out, overflow and zero, output, 1 bit each: result flags.

Function
REQ-014 Subtraction SHALL be x + ~y + 1, with carry-in to digit 0 equal to sel.
REQ-015 c_out SHALL be the MSB carry XOR sel (1 = carry on add, 1 = borrow on subtract); overflow SHALL be the carry into the MSB XOR the carry out of the MSB; zero SHALL be (sum == 0).
REQ-016 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 On IDLE with in_valid=1, the block SHALL capture x, y and sel, clear the digit counter, and go to CALC; input changes after capture SHALL be ignored.
REQ-018 CALC SHALL process one DIGIT-bit slice per cycle, LSB slice first, holding the inter-digit carry in a register; after NDIG cycles it SHALL go to DONE.
REQ-019 out_valid SHALL rise exactly NDIG cycles after the accept edge; with the defaults, an accept at edge T gives out_valid from edge T+4.
REQ-020 In DONE, sum and the flags SHALL be held stable until out_ready=1, then the block SHALL return to IDLE on that edge.
REQ-021 in_valid asserted outside IDLE SHALL have no effect; back-to-back throughput SHALL be one result per NDIG+2 cycles when out_ready is held at 1.
REQ-022 The block SHALL handle the DIGIT == WIDTH case (NDIG = 1) with one CALC cycle.

Reset
REQ-023 When rst_n=0 at a clock edge, the state SHALL become IDLE and sum, c_out, overflow, zero, out_valid, the digit counter and the carry register SHALL be 0; in_ready SHALL be 1.
REQ-024 Reset asserted during CALC or DONE SHALL abort the operation, and no result SHALL be presented afterwards.

Configuration
REQ-025 With macro DIGIT_SERIAL_ADDSUB_SAT_EN defined, a result with overflow=1 SHALL saturate sum to 2^(WIDTH-1)-1 for positive overflow and -2^(WIDTH-1) for negative overflow, with overflow still reported as 1.
REQ-026 Without DIGIT_SERIAL_ADDSUB_SAT_EN, sum SHALL wrap modulo 2^WIDTH, and no saturation logic SHALL be present.

Structure
REQ-027 A shared package alu_pkg SHALL hold the state typedef (IDLE/CALC/DONE) and the sel encoding constants OP_ADD=0 and OP_SUB=1.
REQ-028 One sub-module, addsub_digit, SHALL implement the DIGIT-bit combinational ripple slice (inputs a, b, cin; outputs s, cout, and the carry into the MSB).

Verification
REQ-029 Add test: x=0x0005, y=0x0003, sel=0 -> sum=0x0008, c_out=0, overflow=0, zero=0, out_valid 4 cycles after accept.
REQ-030 Overflow test: x=0x7FFF, y=0x0001, sel=0 -> overflow=1, sum=0x8000, or sum=0x7FFF with SAT_EN defined.
REQ-031 Subtract and zero tests: 0x0003-0x0005 -> sum=0xFFFE, c_out=1, overflow=0; 0x1234-0x1234 -> sum=0x0000, zero=1, c_out=0.
REQ-032 Carry wrap test: x=0xFFFF, y=0x0001, sel=0 -> sum=0x0000, c_out=1, zero=1, overflow=0.
REQ-033 Backpressure test: out_ready=0 for 3 cycles in DONE with in_valid=1 -> sum and flags stable, in_ready=0, no new capture; out_ready=1 -> IDLE on the next edge.
REQ-034 Reset test: rst_n=0 for 1 cycle in the 2nd CALC cycle -> IDLE, in_ready=1, all outputs 0, and out_valid never asserts for the aborted operation.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: controller
// state encoding and the sel operation codes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit combinational ripple slice. Produces the slice sum, the
// carry out of the slice and the carry into the slice's top bit (needed for
// the overflow flag when this slice holds the operand MSB).
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] full;

  // Ripple add with one extra bit to catch the carry out.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  end

  assign s    = full[DIGIT-1:0];
  assign cout = full[DIGIT];
  // Sum bit = a ^ b ^ carry_in, so the carry into the top bit is recoverable.
  assign cmsb = a[DIGIT-1] ^ b[DIGIT-1] ^ full[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor. Processes DIGIT bits per
// cycle, LSB digit first, and presents the full result with c_out, overflow
// and zero flags. Optional macro DIGIT_SERIAL_ADDSUB_SAT_EN enables signed
// saturation of the result on overflow; by default the result wraps.
//
// Handshake: an operand set transfers on a rising edge where in_valid and
// in_ready are both 1; a result transfers on a rising edge where out_valid
// and out_ready are both 1. in_ready is 1 only while idle, out_valid only
// while a result is held, and the held result never changes until it has
// been taken.
module digit_serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state;
  logic [WIDTH-1:0] xs;       // x, shifted right one digit per CALC cycle
  logic [WIDTH-1:0] ys;       // y (pre-inverted for subtract), shifted likewise
  logic [WIDTH-1:0] acc;      // result digits collected from the top down
  logic             carry;    // inter-digit carry
  logic             sel_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] d_s;
  logic             d_cout;
  logic             d_cmsb;
  logic [WIDTH-1:0] xs_next;
  logic [WIDTH-1:0] ys_next;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] res_sum;
  logic             res_ovf;
  logic             last;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (xs[DIGIT-1:0]),
    .b    (ys[DIGIT-1:0]),
    .cin  (carry),
    .s    (d_s),
    .cout (d_cout),
    .cmsb (d_cmsb)
  );

  // With a single digit there is nothing to shift; the slice is the result.
  generate
    if (NDIG == 1) begin : g_single
      assign xs_next  = '0;
      assign ys_next  = '0;
      assign acc_next = d_s;
    end else begin : g_multi
      assign xs_next  = {{DIGIT{1'b0}}, xs[WIDTH-1:DIGIT]};
      assign ys_next  = {{DIGIT{1'b0}}, ys[WIDTH-1:DIGIT]};
      assign acc_next = {d_s, acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign last    = (cnt == CW'(NDIG - 1));
  assign res_ovf = d_cmsb ^ d_cout;

  // Final result value: wrapped, or clamped toward the true sign on overflow.
  always_comb begin
    res_sum = acc_next;
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
    if (res_ovf) begin
      // On overflow the wrapped MSB is the inverse of the true sign.
      if (acc_next[WIDTH-1]) res_sum = {1'b0, {(WIDTH-1){1'b1}}};
      else                   res_sum = {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  // Controller and datapath: capture, digit-serial compute, hold result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      xs        <= '0;
      ys        <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      sel_q     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xs       <= x;
            ys       <= y ^ {WIDTH{sel == OP_SUB}};
            sel_q    <= sel;
            carry    <= (sel == OP_SUB);
            cnt      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          xs    <= xs_next;
          ys    <= ys_next;
          acc   <= acc_next;
          carry <= d_cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum       <= res_sum;
            c_out     <= d_cout ^ sel_q;
            overflow  <= res_ovf;
            zero      <= (res_sum == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench for digit_serial_addsub (WIDTH=16, DIGIT=4).
// Expected results are hand-computed; the overflow cases follow
// DIGIT_SERIAL_ADDSUB_SAT_EN when it is defined.
module tb_digit_serial_addsub;

  localparam int W    = 16;
  localparam int NDIG = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic         zero;

  // {sum, c_out, overflow, zero}
  logic [W+2:0] exp_q[$];
  int           n_checks = 0;
  int           n_err    = 0;

  digit_serial_addsub #(.WIDTH(W), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Monitor / scoreboard: pops on every result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_result: got %h, expected none", {sum, c_out, overflow, zero});
      end else begin
        check("result", 32'({sum, c_out, overflow, zero}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic wait_in_ready();
    int k;
    for (k = 0; k < 20 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Issue one operation and accept it; returns after the accept edge + #1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    wait_in_ready();
    x = a; y = b; sel = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Post-capture changes must not affect the result.
    x = W'($urandom_range(0, 65535));
    y = W'($urandom_range(0, 65535));
    sel = 1'($urandom_range(0, 1));
  endtask

  // Count cycles from the accept edge until out_valid appears.
  task automatic measure_latency(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W+2:0] e);
    int lat;
    out_ready = 1'b1;
    issue(a, b, s);
    exp_q.push_back(e);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    measure_latency(lat);
    check("latency", 32'(lat), 32'(NDIG));
    @(posedge clk); #1;
    check("back_to_idle", 32'({in_ready, out_valid}), 32'b10);
  endtask

  localparam logic [W-1:0] SAT_POS_OR_WRAP =
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
    16'h7FFF;
`else
    16'h8000;
`endif
  localparam logic [W-1:0] SAT_NEG_OR_WRAP =
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
    16'h8000;
`else
    16'h7FFF;
`endif
  localparam logic [W-1:0] SAT_POS2_OR_WRAP =
`ifdef DIGIT_SERIAL_ADDSUB_SAT_EN
    16'h7FFF;
`else
    16'h8001;
`endif

  initial begin
    logic [W+2:0] held;
    int           k;
    bit           seen_valid;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({in_ready, out_valid, sum, c_out, overflow, zero}),
          32'({1'b1, 1'b0, 16'h0000, 3'b000}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: x, y, sel -> {sum, c_out, overflow, zero}
    run_op(16'h0005, 16'h0003, 1'b0, {16'h0008, 3'b000});
    run_op(16'h7FFF, 16'h0001, 1'b0, {SAT_POS_OR_WRAP, 3'b010});
    run_op(16'h0003, 16'h0005, 1'b1, {16'hFFFE, 3'b100});
    run_op(16'h1234, 16'h1234, 1'b1, {16'h0000, 3'b001});
    run_op(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 3'b101});
    run_op(16'h8000, 16'h0001, 1'b1, {SAT_NEG_OR_WRAP, 3'b010});
    run_op(16'h1234, 16'h4321, 1'b0, {16'h5555, 3'b000});
    run_op(16'h0001, 16'h8000, 1'b1, {SAT_POS2_OR_WRAP, 3'b110});

    // Backpressure: hold result 3 cycles with in_valid asserted.
    out_ready = 1'b0;
    issue(16'h0F0F, 16'h0101, 1'b0);
    exp_q.push_back({16'h1010, 3'b000});
    measure_latency(k);
    check("bp_latency", 32'(k), 32'(NDIG));
    held = {sum, c_out, overflow, zero};
    check("bp_first_value", 32'(held), 32'({16'h1010, 3'b000}));
    in_valid = 1'b1; x = 16'hAAAA; y = 16'h5555; sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold", 32'({sum, c_out, overflow, zero}), 32'(held));
      check("bp_flags", 32'({in_ready, out_valid}), 32'b01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'({in_ready, out_valid}), 32'b10);
    @(posedge clk); #1;
    check("bp_no_capture", 32'({in_ready, out_valid}), 32'b10);

    // Reset in the 2nd CALC cycle aborts the operation.
    issue(16'h0002, 16'h0002, 1'b0);
    @(posedge clk);   // first CALC edge done
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_state", 32'({in_ready, out_valid, sum, c_out, overflow, zero}),
          32'({1'b1, 1'b0, 16'h0000, 3'b000}));
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_result", 32'(seen_valid), 32'd0);

    // One more op after abort to confirm normal operation resumes.
    run_op(16'h00FF, 16'h0001, 1'b0, {16'h0100, 3'b000});

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

  // Global timeout guard.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
